// File: rtl/median_filter_pkg.sv
// Shared definitions for the 3x3 median filter.
//   state_t        : frame-level controller states
//   DEF_CH_W       : default bits per colour channel
//   DEF_CHANNELS   : default channels per pixel (channel 0 in the LSBs)
//   channel_t/pixel_t and pixel_channel() : helpers for default-sized pixels
package median_filter_pkg;

    localparam int DEF_CH_W     = 8;
    localparam int DEF_CHANNELS = 3;
    localparam int DEF_PIX_W    = DEF_CH_W * DEF_CHANNELS;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FILL       = 3'd1,
        PROCESSING = 3'd2,
        DRAIN      = 3'd3,
        DONE       = 3'd4
    } state_t;

    typedef logic [DEF_CH_W-1:0]  channel_t;
    typedef logic [DEF_PIX_W-1:0] pixel_t;

    // Extract channel ch of a default-sized pixel.
    function automatic channel_t pixel_channel(input pixel_t px, input int ch);
        return px[ch*DEF_CH_W +: DEF_CH_W];
    endfunction

endpackage

// File: rtl/median_filter_3x3_if.sv
// Stream/control bundle of the 3x3 median filter.
//   start_i     : begin a frame (honoured only while idle)
//   in_valid_i / in_ready_o / in_data_i    : raster-order input pixel stream
//   out_valid_o / out_ready_i / out_data_o : filtered pixel stream
//   done_o      : one-cycle end-of-frame pulse
// modport slave is the filter side, modport master the source/sink side.
interface median_filter_3x3_if #(
    parameter int CH_W     = median_filter_pkg::DEF_CH_W,
    parameter int CHANNELS = median_filter_pkg::DEF_CHANNELS
);
    logic                     start_i;
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic [CHANNELS*CH_W-1:0] in_data_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [CHANNELS*CH_W-1:0] out_data_o;
    logic                     done_o;

    modport slave (
        input  start_i, in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, done_o
    );

    modport master (
        output start_i, in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, done_o
    );
endinterface

// File: rtl/median_of_9.sv
// Combinational exact median (5th smallest) of nine unsigned values.
//   values : nine DATA_W-bit values packed, value 0 in the LSBs
//   median : the median value
// Each value is ranked by counting how many values are strictly smaller and
// how many are smaller-or-equal; the median is any value whose rank range
// covers position 4 (0-based). Ties select equal values, so any hit is right.
module median_of_9
    import median_filter_pkg::*;
#(
    parameter int DATA_W = DEF_CH_W
) (
    input  logic [9*DATA_W-1:0] values,
    output logic [DATA_W-1:0]   median
);
    logic [DATA_W-1:0] v [9];
    logic [8:0]        is_median;

    for (genvar gi = 0; gi < 9; gi++) begin : g_rank
        logic [3:0] less_cnt;
        logic [3:0] less_eq_cnt;

        assign v[gi] = values[gi*DATA_W +: DATA_W];

        always_comb begin
            less_cnt    = '0;
            less_eq_cnt = '0;
            for (int j = 0; j < 9; j++) begin
                if (v[j] < v[gi])  less_cnt    = less_cnt + 4'd1;
                if (v[j] <= v[gi]) less_eq_cnt = less_eq_cnt + 4'd1;
            end
        end

        assign is_median[gi] = (less_cnt <= 4'd4) && (less_eq_cnt >= 4'd5);
    end

    always_comb begin
        median = '0;
        for (int i = 0; i < 9; i++) begin
            if (is_median[i]) median = v[i];
        end
    end
endmodule

// File: rtl/median_filter_3x3.sv
// Streaming 3x3 per-channel median filter over a raster-order frame.
//   clk, rst : clock and synchronous active-high reset
//   bus      : median_filter_3x3_if.slave (start, input stream, output
//              stream, done pulse)
// Rows 0 and 1 only fill the line buffers. From row 2 on, each accepted pixel
// with col>=2 produces the median of the 3x3 window ending at it, registered
// one cycle later. Border pixels produce no output.
module median_filter_3x3
    import median_filter_pkg::*;
#(
    parameter int IMAGE_LEN    = 1080,
    parameter int IMAGE_HEIGHT = 720,
    parameter int CH_W         = DEF_CH_W,
    parameter int CHANNELS     = DEF_CHANNELS
) (
    input  logic               clk,
    input  logic               rst,
    median_filter_3x3_if.slave bus
);
    localparam int PIX_W = CH_W * CHANNELS;
    localparam int COL_W = $clog2(IMAGE_LEN);
    localparam int ROW_W = $clog2(IMAGE_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_LEN - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    state_t             state_reg, state_next;
    logic [COL_W-1:0]   col_reg, col_next;
    logic [ROW_W-1:0]   row_reg, row_next;
    logic               in_ready;
    logic               done;
    logic               accept;
    logic               last_col, last_row;
    logic               frame_start;
    logic               load;

    // Line buffers: lb1 holds row r-1, lb2 holds row r-2.
    logic [PIX_W-1:0]   lb1_mem [IMAGE_LEN];
    logic [PIX_W-1:0]   lb2_mem [IMAGE_LEN];
    logic [PIX_W-1:0]   lb1_rd_reg, lb2_rd_reg;

    // Window columns: index 0 = top (r-2), 1 = middle (r-1), 2 = bottom (r).
    logic [PIX_W-1:0]   cur_col   [3];
    logic [PIX_W-1:0]   prev1_reg [3];
    logic [PIX_W-1:0]   prev2_reg [3];

    logic [PIX_W-1:0]   median_pix;
    logic               out_valid_reg;
    logic [PIX_W-1:0]   out_data_reg;

    assign last_col = (col_reg == COL_LAST);
    assign last_row = (row_reg == ROW_LAST);
    assign accept   = bus.in_valid_i && in_ready;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start_i) state_next = FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                if (bus.in_valid_i && last_col && (row_reg == ROW_ONE))
                    state_next = PROCESSING;
            end
            PROCESSING: begin
                // Accept only when the output register is free or being emptied.
                in_ready = !out_valid_reg || bus.out_ready_i;
                if (bus.in_valid_i && in_ready && last_col && last_row)
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (!out_valid_reg || bus.out_ready_i) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                // Unused encodings behave exactly like IDLE.
                if (bus.start_i) state_next = FILL;
                else             state_next = IDLE;
            end
        endcase
    end

    assign frame_start = (state_next == FILL) && (state_reg != FILL);

    // ----------------------------------------------------------- counters
    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (frame_start) begin
            col_next = '0;
            row_next = '0;
        end else if (accept) begin
            if (last_col) begin
                col_next = '0;
                row_next = row_reg + ROW_W'(1);
            end else begin
                col_next = col_reg + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

    // -------------------------------------------------------- line buffers
    // The read address is the column of the next pixel, so the registered
    // read data always belongs to col_reg. A write (at col_reg) never hits
    // the address being read in the same cycle because an accept advances
    // the column and IMAGE_LEN >= 3.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_mem[col_reg] <= bus.in_data_i;
            lb2_mem[col_reg] <= lb1_rd_reg;
        end
        lb1_rd_reg <= lb1_mem[col_next];
        lb2_rd_reg <= lb2_mem[col_next];
    end

    // ---------------------------------------------------------- window
    assign cur_col[0] = lb2_rd_reg;
    assign cur_col[1] = lb1_rd_reg;
    assign cur_col[2] = bus.in_data_i;

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                prev2_reg[i] <= prev1_reg[i];
                prev1_reg[i] <= cur_col[i];
            end
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [9*CH_W-1:0] window;

        for (genvar gr = 0; gr < 3; gr++) begin : g_row
            assign window[(gr*3+0)*CH_W +: CH_W] = prev2_reg[gr][gi*CH_W +: CH_W];
            assign window[(gr*3+1)*CH_W +: CH_W] = prev1_reg[gr][gi*CH_W +: CH_W];
            assign window[(gr*3+2)*CH_W +: CH_W] = cur_col[gr][gi*CH_W +: CH_W];
        end

        median_of_9 #(
            .DATA_W (CH_W)
        ) u_median (
            .values (window),
            .median (median_pix[gi*CH_W +: CH_W])
        );
    end

    // ------------------------------------------------------ output register
    assign load = accept && (state_reg == PROCESSING) &&
                  (col_reg >= COL_TWO) && (row_reg >= ROW_TWO);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= median_pix;
        end else if (bus.out_ready_i) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_reg;
    assign bus.out_data_o  = out_data_reg;
    assign bus.done_o      = done;
endmodule

// File: tb/tb_median_filter_3x3.sv
// Self-checking bench for median_filter_3x3. Four filter instances of
// different frame sizes share one stimulus driver; sel picks the active one.
module tb_median_filter_3x3;
    import median_filter_pkg::*;

    localparam int CH_W     = 8;
    localparam int CHANNELS = 3;
    localparam int PIX_W    = CH_W * CHANNELS;
    localparam int N_DUT    = 4;
    localparam int N_TESTS  = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             start;
    logic             in_valid;
    logic             out_ready;
    logic [PIX_W-1:0] in_data;
    logic [1:0]       sel;

    logic [N_DUT-1:0]            in_ready_v, out_valid_v, done_v;
    logic [N_DUT-1:0][PIX_W-1:0] out_data_v;

    logic             cur_in_ready, cur_out_valid, cur_done;
    logic [PIX_W-1:0] cur_out_data;

    assign cur_in_ready  = in_ready_v[sel];
    assign cur_out_valid = out_valid_v[sel];
    assign cur_done      = done_v[sel];
    assign cur_out_data  = out_data_v[sel];

    // instance 0: 3x3, 1: 8x6, 2: 8x8, 3: 16x9
    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 3 : (gi == 3) ? 16 : 8;
        localparam int H = (gi == 0) ? 3 : (gi == 1) ? 6 : (gi == 2) ? 8 : 9;

        median_filter_3x3_if #(.CH_W(CH_W), .CHANNELS(CHANNELS)) bus ();

        assign bus.start_i     = start && (sel == 2'(gi));
        assign bus.in_valid_i  = in_valid && (sel == 2'(gi));
        assign bus.in_data_i   = in_data;
        assign bus.out_ready_i = out_ready;
        assign in_ready_v[gi]  = bus.in_ready_o;
        assign out_valid_v[gi] = bus.out_valid_o;
        assign done_v[gi]      = bus.done_o;
        assign out_data_v[gi]  = bus.out_data_o;

        median_filter_3x3 #(
            .IMAGE_LEN    (L),
            .IMAGE_HEIGHT (H),
            .CH_W         (CH_W),
            .CHANNELS     (CHANNELS)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    typedef struct {
        int k;          // instance
        int len;
        int h;
        int kind;       // 0 shuffled 1..9, 1 constant 0x40, 2 impulse, 3 random
        int ready_pct;
        int valid_pct;
        int start_at;   // pixel index at which to pulse start (-1 none)
        int abort_at;   // pixel index at which to assert rst (-1 none)
        int exp_outs;   // expected output count (-1: aborted frame)
        int const_val;  // every output channel must equal this (-1: none)
    } frame_test_t;

    frame_test_t      tbl [N_TESTS];
    logic [PIX_W-1:0] frame_px [256];
    logic [PIX_W-1:0] exp_q [$];

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string msg);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: %s", name, msg);
    endtask

    task automatic gen_frame(input frame_test_t t);
        int perm [9];
        int j, tmp;
        for (int p = 0; p < 256; p++) frame_px[p] = '0;
        case (t.kind)
            0: begin
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    for (int i = 0; i < 9; i++) perm[i] = i + 1;
                    for (int i = 8; i > 0; i--) begin
                        j = int'($urandom_range(0, i));
                        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
                    end
                    for (int i = 0; i < 9; i++) frame_px[i][ch*CH_W +: CH_W] = 8'(perm[i]);
                end
            end
            1: for (int p = 0; p < t.len * t.h; p++) frame_px[p] = 24'h404040;
            2: frame_px[4 * t.len + 3] = 24'hFFFFFF;
            default: for (int p = 0; p < t.len * t.h; p++) frame_px[p] = PIX_W'($urandom);
        endcase
    endtask

    // Reference: sort the nine neighbours of every interior position.
    task automatic build_expected(input int len, input int h);
        int vals [9];
        int n, tmp;
        logic [PIX_W-1:0] px;
        exp_q.delete();
        for (int r = 2; r < h; r++) begin
            for (int c = 2; c < len; c++) begin
                px = '0;
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    n = 0;
                    for (int dr = 0; dr < 3; dr++)
                        for (int dc = 0; dc < 3; dc++) begin
                            vals[n] = int'(frame_px[(r - 2 + dr) * len + (c - 2 + dc)][ch*CH_W +: CH_W]);
                            n++;
                        end
                    for (int a = 0; a < 8; a++)
                        for (int b = 0; b < 8 - a; b++)
                            if (vals[b] > vals[b + 1]) begin
                                tmp = vals[b]; vals[b] = vals[b + 1]; vals[b + 1] = tmp;
                            end
                    px[ch*CH_W +: CH_W] = 8'(vals[4]);
                end
                exp_q.push_back(px);
            end
        end
    endtask

    task automatic run_frame(input frame_test_t t);
        int n_px, pix_idx, cyc, budget, n_out, n_done, post;
        bit stalled, done_seen, pulsed;
        logic [PIX_W-1:0] held, exp_px;
        logic [7:0] cval;
        n_px = t.len * t.h;
        pix_idx = 0; cyc = 0; budget = n_px * 8 + 100;
        n_out = 0; n_done = 0; post = 0;
        stalled = 0; done_seen = 0; pulsed = 0;
        held = '0;
        cval = t.const_val[7:0];
        sel = 2'(t.k);
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (post < 4 && cyc < budget) begin
            if (t.abort_at >= 0 && pix_idx >= t.abort_at) begin
                rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check("abort_state", 64'({cur_out_valid, cur_done, cur_in_ready}), 64'd0);
                $display("[TB] k=%0d rst after %0d pixels, %0d outputs seen", t.k, pix_idx, n_out);
                exp_q.delete();
                return;
            end
            in_valid  = (pix_idx < n_px) && ($urandom_range(0, 99) < t.valid_pct);
            in_data   = (pix_idx < n_px) ? frame_px[pix_idx] : '0;
            out_ready = ($urandom_range(0, 99) < t.ready_pct);
            start     = (t.start_at >= 0) && !pulsed && (pix_idx >= t.start_at);
            if (start) pulsed = 1;
            @(negedge clk);
            if (stalled) begin
                check("stall_valid", 64'(cur_out_valid), 64'd1);
                check("stall_data", 64'(cur_out_data), 64'(held));
            end
            if (cur_out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("extra_output", $sformatf("unexpected pixel %06h", cur_out_data));
                end else begin
                    exp_px = exp_q.pop_front();
                    check("out_data", 64'(cur_out_data), 64'(exp_px));
                    if (t.const_val >= 0)
                        for (int ch = 0; ch < CHANNELS; ch++)
                            check("out_const", 64'(cur_out_data[ch*CH_W +: CH_W]), 64'(cval));
                end
                $display("[TB] k=%0d out #%0d data=%06h", t.k, n_out, cur_out_data);
                n_out++;
            end
            stalled = cur_out_valid && !out_ready;
            held    = cur_out_data;
            if (in_valid && cur_in_ready) pix_idx++;
            if (cur_done) n_done++;
            if (done_seen) post++;
            else if (cur_done) done_seen = 1;
            cyc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        if (!done_seen) fail_now("timeout", $sformatf("no done_o after %0d cycles", cyc));
        check("out_count", 64'(n_out), 64'(t.exp_outs));
        check("done_pulses", 64'(n_done), 64'd1);
        check("pixels_taken", 64'(pix_idx), 64'(n_px));
        $display("[TB] k=%0d frame %0dx%0d: %0d outputs, %0d done pulses", t.k, t.len, t.h, n_out, n_done);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; sel = '0;

        //        k  len h kind rdy val start_at  abort_at  outs const
        tbl[0] = '{0,  3, 3, 0, 100, 100, -1,       -1,        1,  5};
        tbl[1] = '{1,  8, 6, 1, 100, 100, -1,       -1,       24,  'h40};
        tbl[2] = '{2,  8, 8, 2,  70, 100, -1,       -1,       36,  0};
        tbl[3] = '{3, 16, 9, 3,  50, 100, -1,       -1,       98, -1};
        tbl[4] = '{3, 16, 9, 3,  50,  90, 16*3+5,   -1,       98, -1};
        tbl[5] = '{3, 16, 9, 3,  60, 100, -1,       16*4+3,   -1, -1};
        tbl[6] = '{3, 16, 9, 3,  80,  85, -1,       -1,       98, -1};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N_DUT; i++) begin
            check("reset_state", 64'({in_ready_v[i], out_valid_v[i], done_v[i], out_data_v[i]}), 64'd0);
        end

        for (int i = 0; i < N_TESTS; i++) begin
            gen_frame(tbl[i]);
            build_expected(tbl[i].len, tbl[i].h);
            run_frame(tbl[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/median_filter_3x3.md
MEDIAN_FILTER_3X3 -- requirements
Module: median_filter_3x3

Interface
REQ-001 SHALL have parameter IMAGE_LEN, default 1080, pixels per row (>=3).
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 720, rows per frame (>=3).
REQ-003 SHALL have parameter CH_W, default 8, bits per channel.
REQ-004 SHALL have parameter CHANNELS, default 3, channels per pixel (channel 0 in LSBs).
REQ-005 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start_i  input  1  begin a frame; sampled only in IDLE.
REQ-008 SHALL have port in_valid_i  input  1  input pixel valid.
REQ-009 SHALL have port in_ready_o  output  1  block accepts input pixel.
REQ-010 SHALL have port in_data_i  input  CHANNELS*CH_W  raster-order input pixel.
REQ-011 SHALL have port out_valid_o  output  1  filtered pixel valid.
REQ-012 SHALL have port out_ready_i  input  1  downstream accepts output.
REQ-013 SHALL have port out_data_o  output  CHANNELS*CH_W  filtered pixel.
REQ-014 SHALL have port done_o  output  1  one-cycle end-of-frame pulse.

Function
REQ-015 SHALL implement states IDLE, FILL, PROCESSING, DRAIN, DONE.
REQ-016 SHALL move IDLE->FILL on start_i, clearing col/row counters; start_i outside IDLE SHALL be ignored.
REQ-017 SHALL transfer input only when in_valid_i && in_ready_o; output only when out_valid_o && out_ready_i.
REQ-018 SHALL drive in_ready_o=1 in FILL, =(!out_valid_o || out_ready_i) in PROCESSING, 0 otherwise.
REQ-019 SHALL store rows 0 and 1 in FILL (no output), entering PROCESSING after accepting pixel (col=IMAGE_LEN-1,row=1).
REQ-020 SHALL keep two line buffers of IMAGE_LEN pixels (rows r-1, r-2) and a 3x3 window shift register per column.
REQ-021 SHALL, on accepting pixel (col>=2,row>=2), load the output register next cycle with per-channel median of the 3x3 window ending at that pixel (latency 1 cycle).
REQ-022 SHALL compute exact median (5th of 9 sorted values), no averaging, width CH_W, unsigned compare.
REQ-023 SHALL produce exactly (IMAGE_LEN-2)*(IMAGE_HEIGHT-2) outputs per frame; border pixels produce none.
REQ-024 SHALL hold out_valid_o and out_data_o stable while out_valid_o && !out_ready_i.
REQ-025 SHALL allow a new output load in the same cycle the current output is accepted (full throughput, one pixel/cycle).
REQ-026 SHALL wrap col to 0 at IMAGE_LEN-1 and increment row; after last frame pixel accepted SHALL enter DRAIN.
REQ-027 SHALL leave DRAIN for DONE when out_valid_o is 0 or is accepted that cycle.
REQ-028 SHALL assert done_o for exactly one cycle in DONE, then return to IDLE.
REQ-029 SHALL treat unreachable state encodings as IDLE.
REQ-030 SHALL size counters $clog2(IMAGE_LEN) and $clog2(IMAGE_HEIGHT) bits.

Reset
REQ-031 SHALL on rst set state IDLE, counters 0, out_valid_o 0, out_data_o 0, done_o 0, in_ready_o 0.
REQ-032 SHALL abort any frame on rst mid-operation; line buffer contents need not be cleared.

Structure
REQ-033 SHALL place state_t, CH_W/CHANNELS defaults and pixel helper types in median_filter_pkg.
REQ-034 SHALL instantiate sub-module median_of_9 (parameter DATA_W, combinational) once per channel.

Verification
REQ-035 SHALL test 3x3 frame, channel values 1..9 shuffled -> single output 5 per channel, then done_o pulse.
REQ-036 SHALL test 8x6 constant 0x40 frame -> 24 outputs all 0x40, done_o once.
REQ-037 SHALL test impulse: 8x8 zeros with one 0xFF interior pixel -> all 36 outputs 0.
REQ-038 SHALL test random out_ready_i (50%) on random 16x9 frame -> 98 outputs matching model, none dropped/duplicated, data stable while stalled.
REQ-039 SHALL test rst asserted mid-PROCESSING -> next cycle out_valid_o=0, done_o=0, IDLE; following full frame correct.
REQ-040 SHALL test start_i pulsed during PROCESSING -> ignored, frame output count unchanged.
